// File: rtl/rvvi_tx_arbiter_pkg.sv
// Shared definitions for RVVI stream blocks: arbiter state encoding and the
// fixed contents of the beat that terminates an aborted frame.
package cvw;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1,
    ST_ABORT,
    ST_GAP
  } arb_state_t;

  // Aborted frames end with one zero-data beat flagged bad on tuser.
  localparam logic [1023:0] ABORT_DATA  = '0;
  localparam logic          ABORT_TUSER = 1'b1;

endpackage

// File: rtl/rvvi_tx_arbiter_framewatchdog.sv
// Stall counter: counts enabled cycles, and flags expiry on the TIMEOUT-th
// consecutive enabled cycle. Clear wins over enable.
module framewatchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)            cnt <= '0;
    else if (en && (cnt != LIM)) cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt == LIM);

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Frame-atomic arbiter sharing the MAC TX AXI-stream between trace (S0) and
// host-control (S1) frames, with burst limiting, throttle, gap and stall abort.
module rvvi_tx_arbiter
  import cvw::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned MAX_CTRL_BURST = 4,
  parameter int unsigned STALL_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   S0Tdata,
  input  logic [DATA_WIDTH/8-1:0] S0Tkeep,
  input  logic                    S0Tvalid,
  input  logic                    S0Tlast,
  output logic                    S0Tready,
  input  logic [DATA_WIDTH-1:0]   S1Tdata,
  input  logic [DATA_WIDTH/8-1:0] S1Tkeep,
  input  logic                    S1Tvalid,
  input  logic                    S1Tlast,
  output logic                    S1Tready,
  output logic [DATA_WIDTH-1:0]   MTdata,
  output logic [DATA_WIDTH/8-1:0] MTkeep,
  output logic                    MTvalid,
  output logic                    MTlast,
  output logic                    MTuser,
  input  logic                    MTready,
  input  logic                    Throttle,
  output logic [1:0]              Grant,
  output logic                    AbortPulse,
  output logic [15:0]             FrameCount0,
  output logic [15:0]             FrameCount1
);

  localparam int unsigned BW = $clog2(MAX_CTRL_BURST + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CTRL_BURST);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam arb_state_t POST_FRAME   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t    state;
  logic          src1;
  logic [BW-1:0] burst;
  logic [GW-1:0] gap_cnt;
  logic          drain0, drain1;
  logic          s0_elig, s1_req, wd_en, wd_expired, frame_close;

  assign s0_elig = S0Tvalid && !Throttle && !drain0;
  assign s1_req  = S1Tvalid && !drain1;
  assign wd_en   = ((state == ST_GRANT0) && !S0Tvalid) ||
                   ((state == ST_GRANT1) && !S1Tvalid);

  framewatchdog #(.TIMEOUT(STALL_TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (!wd_en),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Data path is pure pass-through; a draining source is always accepted.
  always_comb begin
    MTdata     = '0;
    MTkeep     = '0;
    MTvalid    = 1'b0;
    MTlast     = 1'b0;
    MTuser     = 1'b0;
    S0Tready   = drain0;
    S1Tready   = drain1;
    AbortPulse = 1'b0;
    case (state)
      ST_GRANT0: begin
        MTdata   = S0Tdata;
        MTkeep   = S0Tkeep;
        MTvalid  = S0Tvalid;
        MTlast   = S0Tlast;
        S0Tready = MTready;
      end
      ST_GRANT1: begin
        MTdata   = S1Tdata;
        MTkeep   = S1Tkeep;
        MTvalid  = S1Tvalid;
        MTlast   = S1Tlast;
        S1Tready = MTready;
      end
      ST_ABORT: begin
        MTdata     = ABORT_DATA[DATA_WIDTH-1:0];
        MTkeep     = '1;
        MTvalid    = 1'b1;
        MTlast     = 1'b1;
        MTuser     = ABORT_TUSER;
        AbortPulse = MTready;
      end
      default: ;
    endcase
  end

  assign frame_close = (((state == ST_GRANT0) || (state == ST_GRANT1)) &&
                        MTvalid && MTready && MTlast) ||
                       ((state == ST_ABORT) && MTready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      src1        <= 1'b0;
      Grant       <= 2'b00;
      burst       <= '0;
      gap_cnt     <= '0;
      drain0      <= 1'b0;
      drain1      <= 1'b0;
      FrameCount0 <= '0;
      FrameCount1 <= '0;
    end else begin
      if (drain0 && S0Tvalid && S0Tlast) drain0 <= 1'b0;
      if (drain1 && S1Tvalid && S1Tlast) drain1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s1_req && ((burst < BURST_MAX) || !s0_elig)) begin
            state <= ST_GRANT1;
            src1  <= 1'b1;
            Grant <= 2'b10;
          end else if (s0_elig) begin
            state <= ST_GRANT0;
            src1  <= 1'b0;
            Grant <= 2'b01;
          end
        end
        ST_GRANT0, ST_GRANT1: if (wd_expired) state <= ST_ABORT;
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
      // Aborted frames count as completed for both counters and burst limit.
      if (frame_close) begin
        state   <= POST_FRAME;
        Grant   <= 2'b00;
        gap_cnt <= '0;
        if (src1) begin
          FrameCount1 <= FrameCount1 + 16'd1;
          if (s0_elig && (burst < BURST_MAX)) burst <= burst + BW'(1);
        end else begin
          FrameCount0 <= FrameCount0 + 16'd1;
          burst       <= '0;
        end
      end
      if ((state == ST_ABORT) && MTready) begin
        if (src1) drain1 <= 1'b1;
        else      drain0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Scoreboard bench for rvvi_tx_arbiter: directed frames, expected beats queued
// in output order, monitor compares every MAC-side transfer.
module tb_rvvi_tx_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] S0Tdata, S1Tdata, MTdata;
  logic [3:0]  S0Tkeep, S1Tkeep, MTkeep;
  logic        S0Tvalid, S0Tlast, S0Tready;
  logic        S1Tvalid, S1Tlast, S1Tready;
  logic        MTvalid, MTlast, MTuser, MTready;
  logic        Throttle, AbortPulse;
  logic [1:0]  Grant;
  logic [15:0] FrameCount0, FrameCount1;

  int checks = 0, failures = 0, cyc = 0, aborts = 0, gap_meas = -1, end_cyc = 0;
  bit in_frame = 1'b0;
  beat_t exp_q[$];

  rvvi_tx_arbiter dut (
    .clk(clk), .reset(reset),
    .S0Tdata(S0Tdata), .S0Tkeep(S0Tkeep), .S0Tvalid(S0Tvalid), .S0Tlast(S0Tlast), .S0Tready(S0Tready),
    .S1Tdata(S1Tdata), .S1Tkeep(S1Tkeep), .S1Tvalid(S1Tvalid), .S1Tlast(S1Tlast), .S1Tready(S1Tready),
    .MTdata(MTdata), .MTkeep(MTkeep), .MTvalid(MTvalid), .MTlast(MTlast), .MTuser(MTuser),
    .MTready(MTready), .Throttle(Throttle), .Grant(Grant), .AbortPulse(AbortPulse),
    .FrameCount0(FrameCount0), .FrameCount1(FrameCount1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkd(input int src, input int fr, input int i);
    return {4'(src + 1), 12'(fr), 16'(i)};
  endfunction

  function automatic logic [3:0] kp(input bit last);
    return last ? 4'h3 : 4'hF;
  endfunction

  // Monitor: every MAC-side transfer is matched against the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (reset) in_frame = 1'b0;
    else begin
      if (AbortPulse) aborts++;
      if (MTvalid && MTready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=%h required=none", MTdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", MTdata, e.d);
          chk("beat_keep", 32'(MTkeep), 32'(e.k));
          chk("beat_last", 32'(MTlast), 32'(e.l));
          chk("beat_user", 32'(MTuser), 32'(e.u));
          chk("beat_abort_pulse", 32'(AbortPulse), 32'(e.u));
        end
        if (!in_frame) gap_meas = cyc - end_cyc;
        in_frame = !MTlast;
        if (MTlast) end_cyc = cyc;
      end
    end
  end

  task automatic push_frame(input int src, input int fr, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{d: mkd(src, fr, i), k: kp(i == n - 1), l: (i == n - 1), u: 1'b0});
  endtask

  task automatic send_beat(input int src, input logic [31:0] d, input logic [3:0] k, input logic l);
    int to = 0;
    bit ok = 1'b0;
    if (src == 1) begin S1Tdata = d; S1Tkeep = k; S1Tlast = l; S1Tvalid = 1'b1; end
    else          begin S0Tdata = d; S0Tkeep = k; S0Tlast = l; S0Tvalid = 1'b1; end
    while (!ok && to < 3000) begin
      @(negedge clk);
      ok = (src == 1) ? S1Tready : S0Tready;
      @(posedge clk); #1;
      to++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL handshake_timeout src=%0d actual=no_ready required=ready", src);
    end
  endtask

  task automatic send_frame(input int src, input int fr, input int n);
    for (int i = 0; i < n; i++) send_beat(src, mkd(src, fr, i), kp(i == n - 1), i == n - 1);
    if (src == 1) begin S1Tvalid = 1'b0; S1Tlast = 1'b0; end
    else          begin S0Tvalid = 1'b0; S0Tlast = 1'b0; end
  endtask

  task automatic wait_empty();
    int to = 0;
    while (exp_q.size() != 0 && to < 3000) begin @(posedge clk); to++; end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    reset = 1'b1; Throttle = 1'b0; MTready = 1'b1;
    S0Tdata = '0; S0Tkeep = '0; S0Tvalid = 1'b0; S0Tlast = 1'b0;
    S1Tdata = '0; S1Tkeep = '0; S1Tvalid = 1'b0; S1Tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_mtvalid", 32'(MTvalid), 32'd0);
    chk("rst_mtlast_user", 32'({MTlast, MTuser}), 32'd0);
    chk("rst_treadys", 32'({S0Tready, S1Tready}), 32'd0);
    chk("rst_counts", {FrameCount1, FrameCount0}, 32'd0);
    chk("rst_abort", 32'(AbortPulse), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: single trace frame then back-to-back second frame
    push_frame(0, 0, 4); push_frame(0, 1, 2);
    fork
      begin send_frame(0, 0, 4); send_frame(0, 1, 2); end
      begin
        @(negedge clk); chk("t1_grant_before", 32'(Grant), 32'd0);
        @(negedge clk); chk("t1_grant_after", 32'(Grant), 32'd1);
      end
    join
    wait_empty();
    chk("t1_count0", 32'(FrameCount0), 32'd2);
    chk("t1_frame_gap", 32'(gap_meas), 32'd4);

    // 2: contention, burst limit of four control frames
    for (int f = 0; f < 4; f++) push_frame(1, f, 2);
    push_frame(0, 2, 2);
    for (int f = 4; f < 8; f++) push_frame(1, f, 2);
    push_frame(0, 3, 2);
    fork
      for (int f = 0; f < 8; f++) send_frame(1, f, 2);
      begin send_frame(0, 2, 2); send_frame(0, 3, 2); end
    join
    wait_empty();
    chk("t2_count0", 32'(FrameCount0), 32'd4);
    chk("t2_count1", 32'(FrameCount1), 32'd8);

    // 3: throttle raised mid trace frame
    push_frame(0, 4, 3); push_frame(1, 8, 2); push_frame(1, 9, 2); push_frame(0, 5, 2);
    fork
      begin send_frame(0, 4, 3); send_frame(0, 5, 2); end
      begin wait (Throttle); @(posedge clk); #1; send_frame(1, 8, 2); send_frame(1, 9, 2); end
      begin
        int to = 0;
        do begin @(negedge clk); to++; end
        while (!(MTvalid && MTready && Grant == 2'b01) && to < 100);
        @(posedge clk); #1;
        Throttle = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t3_no_grant_throttled", 32'(Grant), 32'd0);
        chk("t3_s0_not_ready", 32'(S0Tready), 32'd0);
        @(posedge clk); #1;
        Throttle = 1'b0;
      end
    join
    wait_empty();
    chk("t3_count0", 32'(FrameCount0), 32'd6);

    // 4: MAC backpressure mid frame
    a0 = aborts;
    push_frame(1, 10, 6);
    fork
      send_frame(1, 10, 6);
      begin
        int to = 0;
        do begin @(negedge clk); to++; end
        while (!(MTvalid && MTready && MTdata == mkd(1, 10, 1)) && to < 100);
        @(posedge clk); #1;
        MTready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("t4_stall_data", MTdata, mkd(1, 10, 2));
          chk("t4_stall_valid", 32'(MTvalid), 32'd1);
        end
        @(posedge clk); #1;
        MTready = 1'b1;
      end
    join
    wait_empty();
    chk("t4_no_abort", 32'(aborts - a0), 32'd0);

    // 5: stalled trace frame aborted, stale beats drained
    a0 = aborts;
    exp_q.push_back('{d: mkd(0, 6, 0), k: 4'hF, l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: mkd(0, 6, 1), k: 4'hF, l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: 32'h0, k: 4'hF, l: 1'b1, u: 1'b1});
    push_frame(1, 11, 2);
    send_beat(0, mkd(0, 6, 0), 4'hF, 1'b0);
    send_beat(0, mkd(0, 6, 1), 4'hF, 1'b0);
    S0Tvalid = 1'b0;
    repeat (1040) @(posedge clk); #1;
    chk("t5_abort_pulses", 32'(aborts - a0), 32'd1);
    chk("t5_count0", 32'(FrameCount0), 32'd7);
    send_beat(0, mkd(0, 6, 2), 4'hF, 1'b0);
    send_beat(0, mkd(0, 6, 3), 4'h3, 1'b1);
    S0Tvalid = 1'b0; S0Tlast = 1'b0;
    send_frame(1, 11, 2);
    wait_empty();
    chk("t5_count1", 32'(FrameCount1), 32'd12);

    // 6: reset in the middle of a control frame
    exp_q.push_back('{d: mkd(1, 12, 0), k: 4'hF, l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: mkd(1, 12, 1), k: 4'hF, l: 1'b0, u: 1'b0});
    send_beat(1, mkd(1, 12, 0), 4'hF, 1'b0);
    send_beat(1, mkd(1, 12, 1), 4'hF, 1'b0);
    reset = 1'b1;
    S1Tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_grant", 32'(Grant), 32'd0);
    chk("t6_mtvalid", 32'(MTvalid), 32'd0);
    chk("t6_treadys", 32'({S0Tready, S1Tready}), 32'd0);
    chk("t6_counts", {FrameCount1, FrameCount0}, 32'd0);
    chk("t6_partial_beats", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_frame(0, 7, 2);
    send_frame(0, 7, 2);
    wait_empty();
    chk("t6_count0_after", 32'(FrameCount0), 32'd1);
    chk("total_aborts", 32'(aborts), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
